// File: rtl/keypad_event_scanner.sv
// rtl/keypad_event_scanner.sv - matrix keypad scanner with per-key debounce and press/release event FIFO
// Keys are debounced one row per cycle at the start of the dwell that follows each column capture.
module keypad_event_scanner #(
   parameter int NUM_ROWS       = 4,
   parameter int NUM_COLS       = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int KEY_W          = $clog2(NUM_ROWS*NUM_COLS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_ROWS-1:0]          row,
   output logic [NUM_COLS-1:0]          col,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic                         ev_pressed,
   output logic [KEY_W-1:0]             ev_code,
   output logic [NUM_ROWS*NUM_COLS-1:0] key_down,
   output logic [KEY_W-1:0]             key_val,
   output logic                         key_held,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int NK = NUM_ROWS*NUM_COLS;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int CW = $clog2(NUM_COLS);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEBOUNCE_SCANS+1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;

   logic [NUM_ROWS-1:0]   row_s1_q, row_s2_q, row_cap_q;
   logic [DW-1:0]         dwell_q, dwell_d;
   logic [CW-1:0]         col_idx_q, col_idx_d, cap_col_q;
   logic [NK-1:0]         key_down_q;
   logic [BW-1:0]         cnt_q [NK];
   logic [KEY_W-1:0]      key_val_q, key_val_d;
   logic                  key_held_q, key_held_d;
   logic                  overflow_q, overflow_d;
   logic [FIFO_DEPTH-1:0] fifo_pressed_q;
   logic [KEY_W-1:0]      fifo_code_q [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [NW-1:0]         count_q, count_d;

   logic                  dwell_last;
   logic                  proc_en, proc_raw, proc_cur, push, push_ok, pop, full, drop;
   logic [RW-1:0]         proc_row;
   logic [KEY_W-1:0]      proc_code;
   logic [BW-1:0]         proc_cnt;

   always_comb begin
      dwell_last = (dwell_q == DW'(SCAN_DIV-1));
      dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
      col_idx_d  = col_idx_q;
      if (dwell_last) col_idx_d = (col_idx_q == CW'(NUM_COLS-1)) ? '0 : col_idx_q + 1'b1;

      // Row r of the last capture is serviced on dwell cycle r.
      proc_en   = (dwell_q < DW'(NUM_ROWS));
      proc_row  = dwell_q[RW-1:0];
      proc_code = KEY_W'(32'(proc_row) * NUM_COLS + 32'(cap_col_q));
      proc_raw  = ~row_cap_q[proc_row];
      proc_cur  = key_down_q[proc_code];
      proc_cnt  = cnt_q[proc_code];
      push      = proc_en && (proc_raw != proc_cur) && (proc_cnt == BW'(DEBOUNCE_SCANS-1));

      pop     = (count_q != '0) && ev_ready;
      full    = (count_q == NW'(FIFO_DEPTH));
      push_ok = push && (!full || pop);
      drop    = push && full && !pop;

      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set wins over a coincident clear so a fresh drop is never lost.
      overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

      key_val_d  = key_val_q;
      key_held_d = key_held_q;
      if (push && proc_raw) begin
         key_val_d  = proc_code;
         key_held_d = 1'b1;
      end else if (push && (proc_code == key_val_q)) begin
         key_held_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_s1_q       <= '1;
         row_s2_q       <= '1;
         row_cap_q      <= '1;
         dwell_q        <= '0;
         col_idx_q      <= '0;
         cap_col_q      <= '0;
         key_down_q     <= '0;
         key_val_q      <= '0;
         key_held_q     <= 1'b0;
         overflow_q     <= 1'b0;
         fifo_pressed_q <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
         for (int f = 0; f < FIFO_DEPTH; f++) fifo_code_q[f] <= '0;
      end else begin
         row_s1_q   <= row;
         row_s2_q   <= row_s1_q;
         dwell_q    <= dwell_d;
         col_idx_q  <= col_idx_d;
         key_val_q  <= key_val_d;
         key_held_q <= key_held_d;
         overflow_q <= overflow_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (dwell_last) begin
            row_cap_q <= row_s2_q;
            cap_col_q <= col_idx_q;
         end
         if (proc_en) begin
            if (proc_raw == proc_cur) begin
               cnt_q[proc_code] <= '0;
            end else if (push) begin
               cnt_q[proc_code]      <= '0;
               key_down_q[proc_code] <= proc_raw;
            end else begin
               cnt_q[proc_code] <= proc_cnt + 1'b1;
            end
         end
         if (push_ok) begin
            fifo_pressed_q[wr_ptr_q] <= proc_raw;
            fifo_code_q[wr_ptr_q]    <= proc_code;
         end
      end
   end

   assign col        = ~(NUM_COLS'(1) << col_idx_q);
   assign ev_valid   = (count_q != '0);
   assign ev_pressed = fifo_pressed_q[rd_ptr_q];
   assign ev_code    = fifo_code_q[rd_ptr_q];
   assign key_down   = key_down_q;
   assign key_val    = key_val_q;
   assign key_held   = key_held_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// tb/tb_keypad_event_scanner.sv - directed self-checking bench for keypad_event_scanner
module tb_keypad_event_scanner;

   localparam int NR = 4;
   localparam int NC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        ev_valid;
   logic        ev_ready = 1'b1;
   logic        ev_pressed;
   logic [3:0]  ev_code;
   logic [15:0] key_down;
   logic [3:0]  key_val;
   logic        key_held;
   logic        overflow;
   logic        overflow_clr = 1'b0;
   logic [15:0] keys = '0;

   int cyc;
   int checks = 0;
   int errors = 0;
   int ev_code_q[$];
   int ev_pr_q[$];
   int ev_cyc_q[$];

   keypad_event_scanner #(
      .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .row(row), .col(col),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_pressed(ev_pressed), .ev_code(ev_code),
      .key_down(key_down), .key_val(key_val), .key_held(key_held),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = '1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (!col[c] && keys[r*NC+c]) row[r] = 1'b0;
   end

   always @(posedge clk or negedge reset)
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;

   always @(negedge clk)
      if (reset && ev_valid && ev_ready) begin
         ev_code_q.push_back(int'(ev_code));
         ev_pr_q.push_back(int'(ev_pressed));
         ev_cyc_q.push_back(cyc);
      end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_events();
      ev_code_q.delete();
      ev_pr_q.delete();
      ev_cyc_q.delete();
   endtask

   task automatic pad_events(input int n);
      while (ev_code_q.size() < n) begin
         ev_code_q.push_back(-1);
         ev_pr_q.push_back(-1);
         ev_cyc_q.push_back(-1);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      clear_events();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      reset = 1'b0;
      #1;
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
      checks++; if (key_down !== 16'h0) begin errors++; $display("FAIL reset_key_down: got %h expected 0000", key_down); end
      checks++; if ({key_val, key_held, overflow} !== 6'b0) begin errors++; $display("FAIL reset_key_val_held_ovf: got %b expected 000000", {key_val, key_held, overflow}); end
      checks++; if ({ev_pressed, ev_code} !== 5'b0) begin errors++; $display("FAIL reset_head: got %b expected 00000", {ev_pressed, ev_code}); end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      wait_cyc(7);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL scan_col0_dwell: got %b expected 1110", col); end
      wait_cyc(8);
      checks++; if (col !== 4'b1101) begin errors++; $display("FAIL scan_col1: got %b expected 1101", col); end
      wait_cyc(32);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b expected 1110", col); end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL idle_no_event: got %b expected 0", ev_valid); end
   endtask

   task automatic test_single_key();
      keys = 16'h0200;
      do_reset();
      wait_cyc(192);
      checks++; if (ev_code_q.size() !== 1) begin errors++; $display("FAIL press_count: got %0d expected 1", ev_code_q.size()); end
      pad_events(1);
      checks++; if (ev_code_q[0] !== 9 || ev_pr_q[0] !== 1) begin errors++; $display("FAIL press_event: got code %0d pressed %0d expected code 9 pressed 1", ev_code_q[0], ev_pr_q[0]); end
      checks++; if (ev_cyc_q[0] !== 83) begin errors++; $display("FAIL press_latency: got cycle %0d expected 83", ev_cyc_q[0]); end
      checks++; if (key_down !== 16'h0200) begin errors++; $display("FAIL press_key_down: got %h expected 0200", key_down); end
      checks++; if (key_val !== 4'd9 || key_held !== 1'b1) begin errors++; $display("FAIL press_key_val: got %0d held %b expected 9 held 1", key_val, key_held); end
      keys = 16'h0000;
      wait_cyc(300);
      checks++; if (ev_code_q.size() !== 2) begin errors++; $display("FAIL release_count: got %0d expected 2", ev_code_q.size()); end
      pad_events(2);
      checks++; if (ev_code_q[1] !== 9 || ev_pr_q[1] !== 0 || ev_cyc_q[1] !== 275) begin errors++; $display("FAIL release_event: got code %0d pressed %0d cycle %0d expected 9 0 275", ev_code_q[1], ev_pr_q[1], ev_cyc_q[1]); end
      checks++; if (key_held !== 1'b0 || key_down !== 16'h0 || key_val !== 4'd9) begin errors++; $display("FAIL release_state: got held %b down %h val %0d expected 0 0000 9", key_held, key_down, key_val); end
   endtask

   task automatic test_bounce();
      keys = 16'h0001;
      do_reset();
      for (int s = 1; s < 10; s++) begin
         wait_cyc(32*s);
         keys[0] = (s % 2 == 0);
      end
      wait_cyc(320);
      checks++; if (ev_code_q.size() !== 0 || key_down !== 16'h0) begin errors++; $display("FAIL bounce_quiet: got %0d events down %h expected 0 0000", ev_code_q.size(), key_down); end
      keys[0] = 1'b1;
      wait_cyc(420);
      checks++; if (ev_code_q.size() !== 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", ev_code_q.size()); end
      pad_events(1);
      checks++; if (ev_code_q[0] !== 0 || ev_pr_q[0] !== 1 || ev_cyc_q[0] !== 393) begin errors++; $display("FAIL bounce_event: got code %0d pressed %0d cycle %0d expected 0 1 393", ev_code_q[0], ev_pr_q[0], ev_cyc_q[0]); end
   endtask

   task automatic test_simultaneous();
      keys = 16'h4004;
      do_reset();
      wait_cyc(120);
      checks++; if (ev_code_q.size() !== 2) begin errors++; $display("FAIL simul_count: got %0d expected 2", ev_code_q.size()); end
      pad_events(2);
      checks++; if (ev_code_q[0] !== 2 || ev_pr_q[0] !== 1 || ev_cyc_q[0] !== 89) begin errors++; $display("FAIL simul_first: got code %0d pressed %0d cycle %0d expected 2 1 89", ev_code_q[0], ev_pr_q[0], ev_cyc_q[0]); end
      checks++; if (ev_code_q[1] !== 14 || ev_pr_q[1] !== 1 || ev_cyc_q[1] !== 92) begin errors++; $display("FAIL simul_second: got code %0d pressed %0d cycle %0d expected 14 1 92", ev_code_q[1], ev_pr_q[1], ev_cyc_q[1]); end
   endtask

   task automatic test_overflow();
      ev_ready = 1'b0;
      keys = 16'h1113;
      do_reset();
      wait_cyc(78);
      checks++; if (ev_valid !== 1'b1 || ev_code !== 4'd0 || ev_pressed !== 1'b1) begin errors++; $display("FAIL ovf_head_first: got valid %b code %0d pressed %b expected 1 0 1", ev_valid, ev_code, ev_pressed); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_drop: got %b expected 0", overflow); end
      wait_cyc(90);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      checks++; if (ev_code !== 4'd0) begin errors++; $display("FAIL ovf_head_stable: got %0d expected 0", ev_code); end
      checks++; if (key_down !== 16'h1113 || key_val !== 4'd1 || key_held !== 1'b1) begin errors++; $display("FAIL ovf_key_state: got down %h val %0d held %b expected 1113 1 1", key_down, key_val, key_held); end
      clear_events();
      ev_ready = 1'b1;
      wait_cyc(100);
      checks++; if (ev_code_q.size() !== 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", ev_code_q.size()); end
      pad_events(4);
      checks++; if (ev_code_q[0] !== 0 || ev_code_q[1] !== 4 || ev_code_q[2] !== 8 || ev_code_q[3] !== 12) begin errors++; $display("FAIL ovf_drain_order: got %0d %0d %0d %0d expected 0 4 8 12", ev_code_q[0], ev_code_q[1], ev_code_q[2], ev_code_q[3]); end
      checks++; if (ev_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got valid %b ovf %b expected 0 1", ev_valid, overflow); end
      overflow_clr = 1'b1;
      wait_cyc(101);
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_full_pop();
      ev_ready = 1'b0;
      keys = 16'h1113;
      do_reset();
      wait_cyc(80);
      ev_ready = 1'b1;
      wait_cyc(81);
      ev_ready = 1'b0;
      clear_events();
      wait_cyc(85);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_no_drop: got %b expected 0", overflow); end
      checks++; if (ev_valid !== 1'b1 || ev_code !== 4'd4) begin errors++; $display("FAIL fullpop_head: got valid %b code %0d expected 1 4", ev_valid, ev_code); end
      ev_ready = 1'b1;
      wait_cyc(95);
      checks++; if (ev_code_q.size() !== 4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", ev_code_q.size()); end
      pad_events(4);
      checks++; if (ev_code_q[0] !== 4 || ev_code_q[1] !== 8 || ev_code_q[2] !== 12 || ev_code_q[3] !== 1) begin errors++; $display("FAIL fullpop_order: got %0d %0d %0d %0d expected 4 8 12 1", ev_code_q[0], ev_code_q[1], ev_code_q[2], ev_code_q[3]); end
      checks++; if (ev_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_end: got valid %b ovf %b expected 0 0", ev_valid, overflow); end
   endtask

   task automatic test_reset_mid();
      ev_ready = 1'b0;
      keys = 16'h0011;
      do_reset();
      wait_cyc(78);
      checks++; if (ev_valid !== 1'b1 || col !== 4'b1101 || key_val !== 4'd4) begin errors++; $display("FAIL mid_pre: got valid %b col %b val %0d expected 1 1101 4", ev_valid, col, key_val); end
      reset = 1'b0;
      #1;
      checks++; if (col !== 4'b1110 || ev_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_col_valid: got col %b valid %b expected 1110 0", col, ev_valid); end
      checks++; if (key_down !== 16'h0 || key_val !== 4'd0 || key_held !== 1'b0) begin errors++; $display("FAIL mid_reset_keys: got down %h val %0d held %b expected 0000 0 0", key_down, key_val, key_held); end
      repeat (2) @(posedge clk);
      #1;
      clear_events();
      ev_ready = 1'b1;
      reset = 1'b1;
      wait_cyc(100);
      checks++; if (ev_code_q.size() !== 2) begin errors++; $display("FAIL mid_fresh_count: got %0d expected 2", ev_code_q.size()); end
      pad_events(2);
      checks++; if (ev_code_q[0] !== 0 || ev_cyc_q[0] !== 73 || ev_code_q[1] !== 4 || ev_cyc_q[1] !== 74) begin errors++; $display("FAIL mid_fresh_events: got %0d@%0d %0d@%0d expected 0@73 4@74", ev_code_q[0], ev_cyc_q[0], ev_code_q[1], ev_cyc_q[1]); end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_bounce();
      test_simultaneous();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/keypad_event_scanner.md
Name: keypad_event_scanner

Overview:
- Parametrised successor to the fixed 4x4 PMOD keypad decoder.
- Scans an NUM_ROWS x NUM_COLS matrix keypad and debounces every key independently.
- Emits press/release events through a valid/ready FIFO, and also keeps the legacy held-key outputs.
- Sits between the PMOD row/col pins and the music player's key input, on clk_100.

Parameters:
NUM_ROWS, 4, matrix rows (1..8)
NUM_COLS, 4, matrix columns (2..8)
SCAN_DIV, 1000, clk cycles each column is driven; must be >= NUM_ROWS+2
DEBOUNCE_SCANS, 4, consecutive full-matrix scans a key must differ from its debounced state before the change is accepted (>=1)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
KEY_W, $clog2(NUM_ROWS*NUM_COLS), key code width (derived)

Ports:
clk  in  1  system clock; every flop is on the rising edge.
reset  in  1  asynchronous reset, active-low. Asserted low, it immediately clears all state; it is released synchronously by the integrator.
row  in  NUM_ROWS  keypad rows with external pull-ups; low means pressed. Asynchronous input.
col  out  NUM_COLS  one-hot active-low column drive.
ev_valid  out  1  event FIFO non-empty
ev_ready  in  1  consumer accepts the head event
ev_pressed  out  1  head event: 1 = press, 0 = release
ev_code  out  KEY_W  head event key code = row_index*NUM_COLS + col_index
key_down  out  NUM_ROWS*NUM_COLS  debounced state per key, bit = key code
key_val  out  KEY_W  code of most recent debounced press
key_held  out  1  key selected by key_val is still debounced-down
overflow  out  1  sticky flag: an event was dropped
overflow_clr  in  1  single-cycle pulse that clears overflow

Behaviour:
- Reset values while reset is low:
  - col = all ones except bit 0 low; the dwell counter restarts at 0 on column 0.
  - key_down = 0, key_val = 0, key_held = 0, overflow = 0, ev_valid = 0.
  - ev_pressed = 0 and ev_code = 0.
  - All debounce counters are 0 and the FIFO is empty.
- Synchroniser: row passes through a 2-flop synchroniser before any use.
- Scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronised rows are captured into row_cap, the capture is tagged with the current column c, and col advances to (c+1) mod NUM_COLS.
- Row-serial update:
  - On cycles 0..NUM_ROWS-1 of the following dwell, one key (r, c_tagged) is processed per cycle, in ascending r.
  - raw = ~row_cap[r].
  - If raw equals key_down, the key's counter is cleared.
  - Otherwise the counter increments. On reaching DEBOUNCE_SCANS, key_down toggles, the counter clears, and one event {raw, code} is pushed in that same cycle.
- Latency:
  - A stable press is first captured at the end of the key's column dwell.
  - The DEBOUNCE_SCANS-th consecutive differing capture sets key_down and ev_valid on the cycle after that capture's processing cycle.
- key_val / key_held:
  - On a press event, key_val <= code and key_held <= 1.
  - On a release event whose code equals key_val, key_held <= 0.
  - Releases of other keys leave both unchanged.
- FIFO:
  - Pop occurs when ev_valid && ev_ready.
  - ev_pressed and ev_code are the registered head entry and stay stable while ev_valid && !ev_ready.
  - Empty: ev_valid = 0, and ev_ready is ignored.
  - Full with no pop: a push is dropped, overflow is set, and key_down is still updated.
  - Full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Push into an empty FIFO: ev_valid rises the next cycle (there is no fall-through).
- Overflow clear:
  - overflow_clr clears overflow.
  - If overflow_clr coincides with a new drop, overflow stays 1 (set wins).
- Simultaneous keys: several rows in one column produce separate events on consecutive cycles, in ascending row order.
- Reset mid-operation: FIFO contents, debounce progress and the partial dwell are discarded. After reset is released, scanning restarts from column 0.

Test Plan:
All cases use NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, with ev_ready=1 unless stated.
1. Hold key (row 2, col 1) down for 6 full scans.
   - Required: exactly one event, ev_pressed=1, ev_code=9, on the 3rd capture.
   - Then key_down[9]=1, key_val=9, key_held=1.
   - Releasing the key for 3+ scans gives one event with ev_pressed=0, ev_code=9, and key_held=0.
2. Bounce: toggle key 0 every scan for 10 scans, then hold it.
   - Required: no events during the toggling.
   - After holding: a press event exactly 3 scans later.
3. Press rows 0 and 3 of col 2 simultaneously.
   - Required: events for code 2 then code 14, pushed on consecutive cycles.
4. With ev_ready=0, generate 5 press events.
   - Required: ev_valid=1, the head is stable at the first code, and overflow=1 after the 5th.
   - Draining gives exactly 4 events, in order.
   - An overflow_clr pulse clears overflow.
5. Full FIFO with ev_ready=1 on the same cycle as a 5th push.
   - Required: no drop, overflow stays 0, and 4 entries remain.
6. Assert reset low mid-dwell with 2 events queued.
   - Required: outputs clear immediately, with col=4'b1110 and ev_valid=0.
   - Required: after release, the still-held keys generate fresh press events after 3 scans.
